// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
// Holds the FSM state encoding and the default port widths.
package product_accumulator_pkg;

    localparam int DEF_PROD_W = 64;
    localparam int DEF_ACC_W  = 72;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator.sv
// Product accumulator: sums len_i consecutive multiplier products into a
// wide accumulator and presents the total on a valid/ready result port.
//
// Ports:
//   clk, rst (sync, active-low)
//   start_i, len_i          : run request, sampled only in IDLE
//   prod_i, prod_valid_i,
//   prod_ready_o            : product stream in
//   acc_o, acc_valid_o,
//   acc_ready_i             : result stream out
//   busy_o                  : run in progress (ACCUM or DONE)
//   ovf_o                   : sticky carry-out seen during this run
//
// Build option: define PRODUCT_ACCUMULATOR_SAT_EN to saturate acc_o to
// all-ones on overflow instead of wrapping.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic              busy_o,
    output logic              ovf_o
);

    state_t state_q;
    state_t state_d;

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;

    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    assign accept = (state_q == ACCUM) && prod_valid_i && prod_ready_o;
    assign last   = accept && (cnt_q == len_q - LEN_W'(1));

    // One extra bit on the adder captures the carry out of the top bit.
    assign sum   = {1'b0, acc_o}
                 + {{(ACC_W - PROD_W + 1){1'b0}}, prod_i};
    assign carry = sum[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // Once clamped, stay clamped for the rest of the run.
    assign acc_next = (carry || ovf_o) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (acc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_o        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            acc_valid_o  <= 1'b0;
            ovf_o        <= 1'b0;
            prod_ready_o <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_o        <= '0;
                        ovf_o        <= 1'b0;
                        cnt_q        <= '0;
                        len_q        <= len_i;
                        // A zero-length run skips ACCUM entirely.
                        prod_ready_o <= (len_i != '0);
                        acc_valid_o  <= (len_i == '0);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_o <= acc_next;
                        ovf_o <= ovf_o | carry;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last) begin
                            prod_ready_o <= 1'b0;
                            acc_valid_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready_i) begin
                        acc_valid_o <= 1'b0;
                    end
                end
                default: begin
                    prod_ready_o <= 1'b0;
                    acc_valid_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard testbench for product_accumulator (ACC_W=64 to reach overflow).
// Expected sums come from a wide-integer reference model of each run.
module tb_product_accumulator;

    localparam int PW = 64;
    localparam int AW = 64;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic [PW-1:0] prod_i = '0;
    logic          prod_valid_i = 1'b0;
    logic          prod_ready_o;
    logic [AW-1:0] acc_o;
    logic          acc_valid_o;
    logic          acc_ready_i = 1'b0;
    logic          busy_o;
    logic          ovf_o;

    always #5 clk = ~clk;

    product_accumulator #(
        .PROD_W(PW),
        .ACC_W (AW),
        .LEN_W (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .len_i       (len_i),
        .prod_i      (prod_i),
        .prod_valid_i(prod_valid_i),
        .prod_ready_o(prod_ready_o),
        .acc_o       (acc_o),
        .acc_valid_o (acc_valid_o),
        .acc_ready_i (acc_ready_i),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    typedef struct packed {
        logic [AW-1:0] acc;
        logic          ovf;
    } res_t;

    res_t          exp_q[$];
    logic [PW-1:0] prods[$];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact sum in 128 bits, then apply the width rule.
    function automatic res_t model();
        logic [127:0] total;
        res_t         r;
        total = '0;
        foreach (prods[i]) total += {64'd0, prods[i]};
        r.ovf = ((total >> AW) != 0);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        r.acc = r.ovf ? {AW{1'b1}} : total[AW-1:0];
`else
        r.acc = total[AW-1:0];
`endif
        return r;
    endfunction

    // Monitor: compare at every result handshake.
    always @(negedge clk) begin
        res_t e;
        if (rst && acc_valid_o && acc_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_acc", acc_o, e.acc);
                check("result_ovf", ovf_o, e.ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int len, input int max_gap, input int hold,
                       input bit poke_start);
        logic [AW-1:0] held;
        int            guard;
        exp_q.push_back(model());
        start_i = 1'b1;
        len_i   = len[LW-1:0];
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        foreach (prods[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                prod_valid_i = 1'b0;
                prod_i       = {$urandom, $urandom};
                tick();
            end
            prod_valid_i = 1'b1;
            prod_i       = prods[i];
            start_i      = poke_start;
            len_i        = 8'd1;
            guard        = 0;
            while (!prod_ready_o && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check("beat_timeout", 0, 1);
            if (i == prods.size() - 1) check("valid_early", acc_valid_o, 0);
            tick();
            start_i = 1'b0;
        end
        prod_valid_i = 1'b0;
        check("valid_latency", acc_valid_o, 1);
        check("ready_low_in_done", prod_ready_o, 0);
        held = acc_o;
        repeat (hold) begin
            tick();
            check("hold_acc_stable", acc_o, held);
            check("hold_valid", acc_valid_o, 1);
            check("hold_ready_low", prod_ready_o, 0);
        end
        acc_ready_i = 1'b1;
        start_i     = poke_start;
        tick();
        acc_ready_i = 1'b0;
        start_i     = 1'b0;
        check("idle_after_handshake", busy_o, 0);
        check("valid_cleared", acc_valid_o, 0);
        check("acc_kept_in_idle", acc_o, held);
        if (poke_start) begin
            tick();
            check("start_ignored", busy_o, 0);
        end
    endtask

    initial begin
        int guard;
        repeat (2) tick();
        check("rst_acc", acc_o, 0);
        check("rst_valid", acc_valid_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_ready", prod_ready_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b1;
        tick();

        prods = '{64'd6, 64'd10, 64'hFFFF_FFFF_0000_0001};
        run(3, 0, 0, 1'b0);

        prods = '{{$urandom, $urandom}, {$urandom, $urandom}};
        run(2, 3, 5, 1'b0);

        prods.delete();
        run(0, 0, 1, 1'b0);

        prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        run(2, 0, 0, 1'b0);

        prods = '{64'd11, 64'd22, 64'd33};
        run(3, 1, 2, 1'b1);

        // Mid-run reset: one of four beats, then reset; nothing emitted.
        start_i = 1'b1;
        len_i   = 8'd4;
        tick();
        start_i      = 1'b0;
        prod_valid_i = 1'b1;
        prod_i       = 64'd77;
        guard        = 0;
        while (!prod_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("beat_timeout", 0, 1);
        tick();
        prod_valid_i = 1'b0;
        check("midrun_partial", acc_o, 77);
        rst = 1'b0;
        tick();
        check("midrun_rst_acc", acc_o, 0);
        check("midrun_rst_valid", acc_valid_o, 0);
        check("midrun_rst_ready", prod_ready_o, 0);
        check("midrun_rst_busy", busy_o, 0);
        check("midrun_rst_ovf", ovf_o, 0);
        rst = 1'b1;
        tick();

        prods.delete();
        repeat (255) prods.push_back(64'd1);
        run(255, 0, 0, 1'b0);

        repeat (25) begin
            int len;
            len = $urandom_range(6, 0);
            prods.delete();
            repeat (len) begin
                if ($urandom_range(1, 0) == 1)
                    prods.push_back({$urandom, $urandom});
                else
                    prods.push_back({32'd0, $urandom});
            end
            run(len, $urandom_range(2, 0), $urandom_range(3, 0),
                1'($urandom_range(1, 0)));
        end

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 32x32 Karatsuba multiplier's 64-bit product.
- Sums a programmed number of consecutive products into a wide accumulator, i.e. a dot-product / MAC back-end.
- Products arrive on a valid/ready stream; the final sum leaves on a valid/ready result port.
- Sits between the multiplier output register and the result consumer.

Parameters:
- PROD_W, 64, width of incoming product (fixed by the multiplier, 2x32).
- ACC_W, 72, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the term-count field; max 2^LEN_W-1 terms per run.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  pulse: begin a run, sampled only in IDLE
- len_i  in  LEN_W  number of products to sum, sampled with start_i
- prod_i  in  PROD_W  product from multiplier, unsigned
- prod_valid_i  in  1  prod_i is valid
- prod_ready_o  out  1  block accepts prod_i this cycle
- acc_o  out  ACC_W  accumulated result, registered
- acc_valid_o  out  1  acc_o holds a finished sum
- acc_ready_i  in  1  consumer takes acc_o
- busy_o  out  1  high in ACCUM or DONE
- ovf_o  out  1  sticky: sum of the current run exceeded ACC_W bits

Behaviour:
- Reset: the only reset is rst, synchronous active-low. While rst=0 at a clock edge:
  - state<=IDLE;
  - acc_o, term counter, acc_valid_o, ovf_o, prod_ready_o all <= 0;
  - busy_o is 0.
- Reset mid-run discards the partial sum; no result is emitted.
- States: IDLE, ACCUM, DONE (2-bit encoding).
- IDLE:
  - prod_ready_o=0.
  - On start_i=1: acc_o<=0, ovf_o<=0, count<=0, len latched.
  - If len_i==0, go to DONE (result 0); else go to ACCUM.
- ACCUM:
  - prod_ready_o=1, a registered output asserted the cycle after entry.
  - Each cycle with prod_valid_i & prod_ready_o: acc_o <= acc_o + zero-extended prod_i (mod 2^ACC_W), and count increments.
  - A carry out of bit ACC_W-1 sets ovf_o (sticky for the run).
  - The beat where count==len-1 is the last: go to DONE, and prod_ready_o falls next cycle.
  - No beat is accepted when prod_valid_i=0; the block waits indefinitely.
- DONE:
  - acc_valid_o=1; acc_o and ovf_o are held stable until acc_ready_i=1, which completes the handshake.
  - Next cycle: acc_valid_o=0, state=IDLE.
  - acc_o keeps its value in IDLE until the next start.
- start_i outside IDLE is ignored, including start_i=1 in the same cycle as the DONE handshake. A new run needs start_i in IDLE.
- Throughput: one product per cycle in ACCUM. Result latency is 1 cycle after the last accepted beat.
- Products are unsigned. There is no back-pressure to the multiplier other than prod_ready_o.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SAT_EN.
- Defined: on carry out, acc_o clamps to all-ones and stays clamped for the rest of the run; ovf_o is still set.
- Undefined: acc_o wraps modulo 2^ACC_W; ovf_o is set on first carry.

Decomposition:
- Shared package product_accumulator_pkg holds:
  - state enum/localparams IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - default widths PROD_W=64, ACC_W=72, LEN_W=8.
- No sub-module: the adder, counter and FSM fit in a single module.

Test Plan:
- Basic run: reset, start len=3, products 6, 10, 0xFFFF_FFFF_0000_0001 back-to-back, then acc_ready_i=1:
  - acc_o = 0xFFFF_FFFF_0000_0011;
  - acc_valid_o rises 1 cycle after the 3rd beat; ovf_o=0.
- Gaps and back-pressure: len=2, prod_valid_i toggles with idle cycles, acc_ready_i held 0 for 5 cycles:
  - acc_o = sum, stable throughout the hold;
  - prod_ready_o=0 in DONE;
  - IDLE 1 cycle after acc_ready_i.
- Zero length: start len=0 -> DONE next cycle with acc_o=0, acc_valid_o=1, no beats accepted.
- Overflow with ACC_W=64: len=2, products 0xFFFF_FFFF_FFFF_FFFF and 2.
  - Without macro: acc_o=1, ovf_o=1.
  - With PRODUCT_ACCUMULATOR_SAT_EN: acc_o=0xFFFF_FFFF_FFFF_FFFF, ovf_o=1.
- Ignored start and mid-run reset:
  - start_i pulsed during ACCUM and in the DONE handshake cycle -> no effect, state IDLE after handshake.
  - Later rst=0 after 1 of 4 beats -> all outputs 0 next edge, no acc_valid_o.
- Max length: len=255 with every product = 1 -> acc_o=255, count does not wrap early, ovf_o=0.
